// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Producer side of the instruction buffer. Holds the fetch PC, issues one
// instruction-memory read at a time and pushes each returned word into the
// instruction buffer, respecting the buffer-full flag. A redirect from branch
// resolution reloads the PC and kills whatever fetch is in flight.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched and
// perf_full_stall performance counters. Without it those ports are absent.

module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,

    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,

    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data_in,
    input  logic                  buf_is_full,

`ifdef FETCH_PERF_EN
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_full_stall,
`endif

    output logic [ADDR_WIDTH-1:0] fetch_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    drop;
    logic [INST_WIDTH-1:0]   hold;
    logic                    req_valid_q;

    logic                    handshake;
    logic                    write_fire;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic [ADDR_WIDTH-1:0]   pc_next_seq;

    // Decode of the request handshake, the buffer write strobe and the two PC candidates.
    always_comb begin
        handshake       = req_valid_q && imem_req_ready;
        write_fire      = (state == WRITE) && !buf_is_full && !redirect_valid;
        redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
        pc_next_seq     = pc + ADDR_WIDTH'(4);
    end

    // Fetch FSM: PC, drop flag for a killed fetch, held word, and the registered request valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            hold        <= '0;
            req_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end else if (!stall) begin
                        state       <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (handshake) begin
                        state       <= WAIT;
                        req_valid_q <= 1'b0;
                        drop        <= redirect_valid;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            drop        <= 1'b0;
                            state       <= REQ;
                            req_valid_q <= 1'b1;
                            if (redirect_valid) begin
                                pc <= redirect_target;
                            end
                        end else begin
                            hold  <= imem_rsp_data;
                            state <= WRITE;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_target;
                        drop <= 1'b1;
                    end
                end

                WRITE: begin
                    if (redirect_valid) begin
                        pc          <= redirect_target;
                        state       <= REQ;
                        req_valid_q <= 1'b1;
                    end else if (!buf_is_full) begin
                        pc <= pc_next_seq;
                        if (stall) begin
                            state <= IDLE;
                        end else begin
                            state       <= REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: words written into the buffer and cycles blocked by a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched    <= '0;
            perf_full_stall <= '0;
        end else begin
            if (write_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == WRITE) && buf_is_full) begin
                perf_full_stall <= perf_full_stall + 32'd1;
            end
        end
    end
`endif

    // Output wiring from the registered state.
    always_comb begin
        imem_req_valid = req_valid_q;
        imem_req_addr  = pc;
        fetch_pc       = pc;
        buf_write_en   = write_fire;
        buf_data_in    = hold;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Directed scenarios followed by a randomized run. A small memory model answers
// requests after a chosen latency; the reference tracks the architectural fetch
// PC (sequential +4, reloaded by redirects) and the word each PC must deliver.

module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        buf_write_en;
    logic [31:0] buf_data_in;
    logic        buf_is_full;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_full_stall;
`endif

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .buf_write_en   (buf_write_en),
        .buf_data_in    (buf_data_in),
        .buf_is_full    (buf_is_full),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched),
        .perf_full_stall (perf_full_stall),
`endif
        .fetch_pc       (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // values applied to the DUT at the start of the next cycle
    logic        drv_stall;
    logic        drv_redirect;
    logic [31:0] drv_redirect_pc;
    logic        drv_full;
    logic        drv_ready;

    // memory model
    logic        fixed_en;
    logic [31:0] fixed_word;
    int          lat_min;
    int          lat_max;
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_cnt;

    // reference state
    logic [31:0] exp_pc;
    int          wr_count;
    logic [31:0] hs_q[$];
    int          base;
    int          hs_base;

    function automatic logic [31:0] word_for(input logic [31:0] addr);
        return fixed_en ? fixed_word : (addr * 32'h9E37_79B1) + 32'h1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: apply inputs and memory response after the falling edge,
    // check the settled outputs against the reference, then advance the reference.
    task automatic applyStimulus();
        @(negedge clk);
        stall          = drv_stall;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        buf_is_full    = drv_full;
        imem_req_ready = drv_ready;
        if (pend_valid && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_for(pend_addr);
            pend_valid     = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend_valid) pend_cnt--;
        end
        #1;
        if (rst_n) begin
            checkOutput("fetch_pc", fetch_pc, exp_pc);
            if (imem_req_valid) checkOutput("req_addr", imem_req_addr, exp_pc);
            checkOutput("write_while_full", 32'(buf_write_en & buf_is_full), 32'd0);
            checkOutput("write_on_redirect", 32'(buf_write_en & redirect_valid), 32'd0);
            if (buf_write_en) begin
                checkOutput("buf_data", buf_data_in, word_for(exp_pc));
                wr_count++;
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("single_outstanding", 32'(pend_valid), 32'd0);
                hs_q.push_back(imem_req_addr);
                pend_valid = 1'b1;
                pend_addr  = imem_req_addr;
                pend_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            else if (buf_write_en) exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_write_en"}, 32'(buf_write_en), 32'd0);
        checkOutput({tag, "_data_in"}, buf_data_in, 32'd0);
        checkOutput({tag, "_fetch_pc"}, fetch_pc, RESET_PC);
        checkOutput({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        buf_is_full = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        drv_stall = 1'b0; drv_redirect = 1'b0; drv_redirect_pc = '0;
        drv_full = 1'b0; drv_ready = 1'b1;
        fixed_en = 1'b1; fixed_word = 32'h0000_0013;
        lat_min = 1; lat_max = 1;
        pend_valid = 1'b0; pend_addr = '0; pend_cnt = 0;
        exp_pc = RESET_PC; wr_count = 0;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // scenario 1: three sequential fetches, stall raised after the second write
        for (int g = 0; g < 40 && wr_count < 3; g++) begin
            drv_stall = (wr_count >= 2);
            applyStimulus();
        end
        checkOutput("t1_writes", wr_count, 32'd3);
        checkOutput("t1_hs_count", hs_q.size(), 32'd3);
        if (hs_q.size() >= 3) begin
            checkOutput("t1_addr0", hs_q[0], 32'h0);
            checkOutput("t1_addr1", hs_q[1], 32'h4);
            checkOutput("t1_addr2", hs_q[2], 32'h8);
        end

        // scenario 5: parked in IDLE while stalled, resumes at pc+4
        drv_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("t5_parked_no_req", 32'(imem_req_valid), 32'd0);
        end
        checkOutput("t1_fetch_pc", fetch_pc, 32'hC);
        drv_stall = 1'b0;
        applyStimulus();
        checkOutput("t5_idle_no_req", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        checkOutput("t5_resume_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t5_resume_addr", imem_req_addr, 32'hC);

        // scenario 2: buffer full for five cycles in WRITE
        fixed_word = 32'hCAFE_0001;
        base = wr_count;
        for (int i = 0; i < 6; i++) begin
            drv_full = 1'b1;
            applyStimulus();
            checkOutput("t2_no_write_full", 32'(buf_write_en), 32'd0);
            if (i > 0) checkOutput("t2_data_held", buf_data_in, 32'hCAFE_0001);
        end
        drv_full = 1'b0;
        applyStimulus();
        checkOutput("t2_write_on_release", 32'(buf_write_en), 32'd1);
        checkOutput("t2_write_data", buf_data_in, 32'hCAFE_0001);
        checkOutput("t2_write_count", wr_count - base, 32'd1);

        // scenario 3: redirect to 0x103 while waiting; stale response dropped
        fixed_word = 32'hDEAD_BEEF;
        lat_min = 3; lat_max = 3;
        base = wr_count;
        applyStimulus();
        checkOutput("t3_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t3_req_addr", imem_req_addr, 32'h10);
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0103;
        applyStimulus();
        drv_redirect = 1'b0;
        lat_min = 1; lat_max = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("t3_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        checkOutput("t3_no_write", wr_count - base, 32'd0);
        applyStimulus();
        checkOutput("t3_new_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t3_new_req_addr", imem_req_addr, 32'h100);
        for (int g = 0; g < 10 && wr_count == base; g++) applyStimulus();
        checkOutput("t3_refetch_write", wr_count - base, 32'd1);

        // scenario 4: ready low for four cycles, redirect to 0x40 on the second
        fixed_en = 1'b0;
        drv_ready = 1'b0;
        hs_base = hs_q.size();
        base = wr_count;
        applyStimulus();
        checkOutput("t4_first_addr", imem_req_addr, 32'h104);
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0040;
        applyStimulus();
        drv_redirect = 1'b0;
        applyStimulus();
        checkOutput("t4_addr_changed", imem_req_addr, 32'h40);
        checkOutput("t4_still_valid", 32'(imem_req_valid), 32'd1);
        applyStimulus();
        drv_ready = 1'b1;
        applyStimulus();
        checkOutput("t4_hs_count", hs_q.size() - hs_base, 32'd1);
        if (hs_q.size() > hs_base) checkOutput("t4_hs_addr", hs_q[hs_base], 32'h40);
        for (int g = 0; g < 10 && wr_count == base; g++) applyStimulus();
        checkOutput("t4_write_count", wr_count - base, 32'd1);
        checkOutput("t4_write_data", buf_data_in, word_for(32'h40));

        // scenario 6: asynchronous reset while waiting for a response
        lat_min = 3; lat_max = 3;
        applyStimulus();
        checkOutput("t6_req_valid", 32'(imem_req_valid), 32'd1);
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6_async");
        pend_valid = 1'b0;
        exp_pc = RESET_PC;
        lat_min = 1; lat_max = 1;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
`ifdef FETCH_PERF_EN
        checkOutput("t6_perf_fetched_rst", perf_fetched, 32'd0);
        checkOutput("t6_perf_full_rst", perf_full_stall, 32'd0);
`endif
        base = wr_count;
        for (int g = 0; g < 20 && wr_count == base; g++) applyStimulus();
        checkOutput("t6_first_write", wr_count - base, 32'd1);
        drv_full = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("t6_no_write_full", wr_count - base, 32'd1);
        drv_full = 1'b0;
        applyStimulus();
        checkOutput("t6_second_write", 32'(buf_write_en), 32'd1);
        drv_stall = 1'b1;
        applyStimulus();
        drv_stall = 1'b0;
`ifdef FETCH_PERF_EN
        checkOutput("t6_perf_fetched", perf_fetched, 32'd2);
        checkOutput("t6_perf_full", perf_full_stall, 32'd5);
`endif

        // PC wrap: redirect near the top of the address space
        drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFFE;
        applyStimulus();
        drv_redirect = 1'b0;
        base = wr_count;
        for (int g = 0; g < 20 && wr_count == base; g++) applyStimulus();
        applyStimulus();
        checkOutput("wrap_pc", fetch_pc, 32'h0);

        // randomized traffic
        base = wr_count;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            drv_stall    = ($urandom_range(99, 0) < 25);
            drv_redirect = ($urandom_range(99, 0) < 6);
            drv_redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            drv_full     = ($urandom_range(99, 0) < 30);
            drv_ready    = ($urandom_range(99, 0) < 70);
            applyStimulus();
        end
        checkOutput("random_progress", 32'(wr_count - base >= 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
